regs_file: RTL and testbench
============================

Name: regs_file

Overview:
- Integer register file serving the decode stage.
- The decode stage drives rs1/rs2 read addresses and consumes the read data; the execute/writeback path drives rd_addr, reg_wen and the result.
- 32 x 32-bit registers, x0 hardwired to zero, two read ports and one write port.
- Write-to-read bypass and a per-register pending-write scoreboard, so the decode stage can detect read-after-write hazards.

Parameters:
- ADDR_W, 5, register index width (32 entries).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rs1_addr_i  input  5  read port 1 index, from decode.
- rs2_addr_i  input  5  read port 2 index, from decode.
- rs1_data_o  output  32  read port 1 data.
- rs2_data_o  output  32  read port 2 data.
- rd_addr_i  input  5  write index, from writeback.
- rd_data_i  input  32  write data.
- reg_wen_i  input  1  write enable.
- issue_valid_i  input  1  decode issues an instruction that will write issue_rd_i.
- issue_rd_i  input  5  destination of the issued instruction.
- hazard_o  output  1  a source of the current read addresses is pending.
- busy_o  output  32  scoreboard vector, bit n = xn pending.
- wr_count_o  output  32  count of committed non-x0 writes.

Behaviour:
- Reset (rst=0, asynchronous):
  - All 32 registers cleared to 0.
  - busy_o = 0, wr_count_o = 0.
  - While reset is low, read data reflects the cleared array (0).
  - hazard_o = 0.
  - Reset asserted mid-operation discards pending writes and scoreboard bits immediately.
- Write:
  - On the rising clk edge with reg_wen_i=1 and rd_addr_i!=0: reg[rd_addr_i] <= rd_data_i, and wr_count_o increments by 1.
  - wr_count_o wraps from 0xFFFFFFFF to 0.
  - reg_wen_i=1 with rd_addr_i=0 is ignored: no write, no count.
- Read (combinational, zero latency):
  - Address 0 returns 0.
  - Else, if reg_wen_i=1 and rd_addr_i equals the read address, return rd_data_i (bypass).
  - Otherwise return the array value.
  - Each port evaluates independently; both may hit the bypass in the same cycle.
- Scoreboard (registered, updated on clk edge):
  - issue_valid_i=1 and issue_rd_i!=0 sets busy[issue_rd_i].
  - reg_wen_i=1 and rd_addr_i!=0 clears busy[rd_addr_i].
  - Same index set and cleared in one cycle: set wins (a newer producer is outstanding).
  - Different indices: both take effect.
  - Clearing an index that is not busy is harmless.
  - busy[0] is always 0.
- Hazard (combinational):
  - hazard_o = (rs1_addr_i!=0 and busy[rs1] and not bypass-hit on rs1) OR (the same term for rs2).
  - A source being written this cycle is not a hazard, because the bypass supplies the data.
  - Decode zeroes unused source addresses, so x0 never raises a hazard.
- No internal state machine beyond the array, scoreboard and counter; all state is updated in a single clocked always block with asynchronous reset.

Test Plan:
1. Reset then read: rst low 2 cycles, release; rs1_addr_i=5, rs2_addr_i=31 -> rs1_data_o=0, rs2_data_o=0, busy_o=0, wr_count_o=0.
2. Write and read back: write x3=0x0000_00AA at edge N; cycle N+1 with rs1_addr_i=3 -> rs1_data_o=0x0000_00AA, wr_count_o=1.
3. x0 protection: reg_wen_i=1, rd_addr_i=0, rd_data_i=0xDEAD_BEEF; read x0 -> 0 (same cycle and next), wr_count_o unchanged.
4. Bypass:
   - x7 holds 0x11; same cycle reg_wen_i=1, rd_addr_i=7, rd_data_i=0x22, rs1_addr_i=rs2_addr_i=7 -> both outputs 0x22 combinationally.
   - Next cycle the array holds 0x22.
5. Scoreboard:
   - issue_valid_i=1, issue_rd_i=9 -> next cycle busy_o[9]=1; rs2_addr_i=9 -> hazard_o=1.
   - Cycle with reg_wen_i=1, rd_addr_i=9 -> hazard_o=0 that cycle, busy_o[9]=0 after the edge.
   - Same edge issue x9 and write x9 -> busy_o[9] stays 1.
6. Async reset mid-operation: busy x4, x4=0x5; assert rst between clock edges -> outputs/busy/counter zero immediately without a clock edge; subsequent reads of x4 return 0.

Source files
------------

// File: rtl/regs_file_if.sv
// Register file interface: decode read ports, writeback write port,
// issue tracking and status outputs grouped as one bundle.
interface regs_file_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              reg_wen_i;
  logic              issue_valid_i;
  logic [ADDR_W-1:0] issue_rd_i;
  logic              hazard_o;
  logic [NREGS-1:0]  busy_o;
  logic [31:0]       wr_count_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, reg_wen_i,
           issue_valid_i, issue_rd_i,
    input  rs1_data_o, rs2_data_o, hazard_o, busy_o, wr_count_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, reg_wen_i,
           issue_valid_i, issue_rd_i,
    output rs1_data_o, rs2_data_o, hazard_o, busy_o, wr_count_o
  );
endinterface

// File: rtl/regs_file.sv
// Integer register file: 2 read / 1 write ports, x0 hardwired to zero,
// write-to-read bypass and a pending-write scoreboard for RAW hazard detection.
module regs_file #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  regs_file_if.slave  rf
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = 32;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;

  logic              wr_fire_s;
  logic              issue_fire_s;
  logic              rs1_hit_s;
  logic              rs2_hit_s;
  logic              rs1_pend_s;
  logic              rs2_pend_s;

  // A read port returns zero for x0, the in-flight write on a bypass hit,
  // and the stored value otherwise.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] arr_data
  );
    logic [DATA_W-1:0] res;
    if (addr == {ADDR_W{1'b0}}) begin
      res = {DATA_W{1'b0}};
    end else if (hit) begin
      res = wr_data;
    end else begin
      res = arr_data;
    end
    return res;
  endfunction

  // Qualified write/issue strobes and per-port bypass detection.
  always_comb begin
    wr_fire_s    = rf.reg_wen_i && (rf.rd_addr_i != {ADDR_W{1'b0}});
    issue_fire_s = rf.issue_valid_i && (rf.issue_rd_i != {ADDR_W{1'b0}});
    rs1_hit_s    = wr_fire_s && (rf.rd_addr_i == rf.rs1_addr_i);
    rs2_hit_s    = wr_fire_s && (rf.rd_addr_i == rf.rs2_addr_i);
  end

  // Combinational read ports and hazard flag.
  always_comb begin
    rf.rs1_data_o = read_port(rf.rs1_addr_i, rs1_hit_s, rf.rd_data_i, regs_q[rf.rs1_addr_i]);
    rf.rs2_data_o = read_port(rf.rs2_addr_i, rs2_hit_s, rf.rd_data_i, regs_q[rf.rs2_addr_i]);
    // A source written this cycle is covered by the bypass, so it is not a hazard.
    rs1_pend_s  = (rf.rs1_addr_i != {ADDR_W{1'b0}}) && busy_q[rf.rs1_addr_i] && !rs1_hit_s;
    rs2_pend_s  = (rf.rs2_addr_i != {ADDR_W{1'b0}}) && busy_q[rf.rs2_addr_i] && !rs2_hit_s;
    rf.hazard_o = rs1_pend_s || rs2_pend_s;
  end

  // Next-state scoreboard and write counter.
  always_comb begin
    busy_d     = busy_q;
    wr_count_d = wr_count_q;
    if (wr_fire_s) begin
      busy_d[rf.rd_addr_i] = 1'b0;
      wr_count_d           = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    // Applied after the clear so a newer producer on the same index wins.
    if (issue_fire_s) begin
      busy_d[rf.issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Array, scoreboard and counter state with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q     <= {NREGS{1'b0}};
      wr_count_q <= {CNT_W{1'b0}};
    end else begin
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
      if (wr_fire_s) begin
        regs_q[rf.rd_addr_i] <= rf.rd_data_i;
      end
    end
  end

  // Status outputs come straight from registers.
  always_comb begin
    rf.busy_o     = busy_q;
    rf.wr_count_o = wr_count_q;
  end
endmodule

// File: tb/tb_regs_file.sv
// Directed self-checking bench for regs_file: reset, write/readback, x0,
// bypass, scoreboard set/clear priority and asynchronous reset mid-run.
module tb_regs_file;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  regs_file_if #(.ADDR_W(5), .DATA_W(32)) rf_if ();

  regs_file #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rf_if.rs1_addr_i    = 5'd0;
    rf_if.rs2_addr_i    = 5'd0;
    rf_if.rd_addr_i     = 5'd0;
    rf_if.rd_data_i     = 32'd0;
    rf_if.reg_wen_i     = 1'b0;
    rf_if.issue_valid_i = 1'b0;
    rf_if.issue_rd_i    = 5'd0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    idle_inputs();

    // 1. Reset then read
    step();
    step();
    check("rst_busy_during", rf_if.busy_o, 32'h0);
    rst = 1'b1;
    rf_if.rs1_addr_i = 5'd5;
    rf_if.rs2_addr_i = 5'd31;
    #1;
    check("rst_rs1", rf_if.rs1_data_o, 32'h0);
    check("rst_rs2", rf_if.rs2_data_o, 32'h0);
    check("rst_busy", rf_if.busy_o, 32'h0);
    check("rst_count", rf_if.wr_count_o, 32'h0);
    check("rst_hazard", {31'd0, rf_if.hazard_o}, 32'h0);

    // 2. Write x3 and read back
    rf_if.reg_wen_i = 1'b1;
    rf_if.rd_addr_i = 5'd3;
    rf_if.rd_data_i = 32'h0000_00AA;
    step();
    rf_if.reg_wen_i  = 1'b0;
    rf_if.rs1_addr_i = 5'd3;
    #1;
    check("wr_x3_rs1", rf_if.rs1_data_o, 32'h0000_00AA);
    check("wr_x3_count", rf_if.wr_count_o, 32'd1);

    // 3. x0 protection
    rf_if.reg_wen_i  = 1'b1;
    rf_if.rd_addr_i  = 5'd0;
    rf_if.rd_data_i  = 32'hDEAD_BEEF;
    rf_if.rs1_addr_i = 5'd0;
    rf_if.rs2_addr_i = 5'd0;
    #1;
    check("x0_same_rs1", rf_if.rs1_data_o, 32'h0);
    check("x0_same_rs2", rf_if.rs2_data_o, 32'h0);
    step();
    rf_if.reg_wen_i = 1'b0;
    #1;
    check("x0_next_rs1", rf_if.rs1_data_o, 32'h0);
    check("x0_count", rf_if.wr_count_o, 32'd1);

    // 4. Bypass on both ports
    rf_if.reg_wen_i = 1'b1;
    rf_if.rd_addr_i = 5'd7;
    rf_if.rd_data_i = 32'h0000_0011;
    step();
    rf_if.rd_data_i  = 32'h0000_0022;
    rf_if.rs1_addr_i = 5'd7;
    rf_if.rs2_addr_i = 5'd7;
    #1;
    check("byp_rs1", rf_if.rs1_data_o, 32'h0000_0022);
    check("byp_rs2", rf_if.rs2_data_o, 32'h0000_0022);
    check("byp_count_pre", rf_if.wr_count_o, 32'd2);
    step();
    rf_if.reg_wen_i  = 1'b0;
    rf_if.rs2_addr_i = 5'd3;
    #1;
    check("byp_array", rf_if.rs1_data_o, 32'h0000_0022);
    check("indep_rs2_x3", rf_if.rs2_data_o, 32'h0000_00AA);
    check("byp_count_post", rf_if.wr_count_o, 32'd3);

    // 5. Scoreboard set, hazard, clear via write
    rf_if.issue_valid_i = 1'b1;
    rf_if.issue_rd_i    = 5'd9;
    step();
    rf_if.issue_valid_i = 1'b0;
    rf_if.rs1_addr_i    = 5'd0;
    rf_if.rs2_addr_i    = 5'd9;
    #1;
    check("sb_busy9", rf_if.busy_o, 32'h0000_0200);
    check("sb_hazard", {31'd0, rf_if.hazard_o}, 32'd1);
    rf_if.reg_wen_i = 1'b1;
    rf_if.rd_addr_i = 5'd9;
    rf_if.rd_data_i = 32'h0000_0099;
    #1;
    check("sb_hazard_byp", {31'd0, rf_if.hazard_o}, 32'd0);
    check("sb_byp_data", rf_if.rs2_data_o, 32'h0000_0099);
    step();
    rf_if.reg_wen_i = 1'b0;
    #1;
    check("sb_cleared", rf_if.busy_o, 32'h0);
    check("sb_hazard_off", {31'd0, rf_if.hazard_o}, 32'd0);
    check("sb_count", rf_if.wr_count_o, 32'd4);

    // Set wins over clear on the same index
    rf_if.issue_valid_i = 1'b1;
    rf_if.issue_rd_i    = 5'd9;
    step();
    rf_if.reg_wen_i = 1'b1;
    rf_if.rd_addr_i = 5'd9;
    rf_if.rd_data_i = 32'h0000_0077;
    step();
    rf_if.reg_wen_i     = 1'b0;
    rf_if.issue_valid_i = 1'b0;
    #1;
    check("sb_set_wins", rf_if.busy_o, 32'h0000_0200);
    check("sb_set_wins_hz", {31'd0, rf_if.hazard_o}, 32'd1);
    check("sb_x9_data", rf_if.rs2_data_o, 32'h0000_0077);

    // Different indices: set x12, clear x9
    rf_if.issue_valid_i = 1'b1;
    rf_if.issue_rd_i    = 5'd12;
    rf_if.reg_wen_i     = 1'b1;
    rf_if.rd_addr_i     = 5'd9;
    rf_if.rd_data_i     = 32'h0000_0055;
    step();
    rf_if.issue_valid_i = 1'b0;
    rf_if.reg_wen_i     = 1'b0;
    #1;
    check("sb_diff_idx", rf_if.busy_o, 32'h0000_1000);
    check("sb_diff_count", rf_if.wr_count_o, 32'd6);

    // 6. Asynchronous reset mid-operation
    rf_if.reg_wen_i = 1'b1;
    rf_if.rd_addr_i = 5'd4;
    rf_if.rd_data_i = 32'h0000_0005;
    step();
    rf_if.reg_wen_i     = 1'b0;
    rf_if.issue_valid_i = 1'b1;
    rf_if.issue_rd_i    = 5'd4;
    step();
    rf_if.issue_valid_i = 1'b0;
    rf_if.rs1_addr_i    = 5'd4;
    rf_if.rs2_addr_i    = 5'd0;
    #1;
    check("ar_pre_busy", rf_if.busy_o, 32'h0000_1010);
    check("ar_pre_x4", rf_if.rs1_data_o, 32'h0000_0005);
    check("ar_pre_hazard", {31'd0, rf_if.hazard_o}, 32'd1);
    check("ar_pre_count", rf_if.wr_count_o, 32'd7);
    #1;
    rst = 1'b0;
    #1;
    check("ar_busy", rf_if.busy_o, 32'h0);
    check("ar_count", rf_if.wr_count_o, 32'h0);
    check("ar_x4", rf_if.rs1_data_o, 32'h0);
    check("ar_hazard", {31'd0, rf_if.hazard_o}, 32'd0);
    #1;
    rst = 1'b1;
    step();
    rf_if.rs2_addr_i = 5'd3;
    #1;
    check("ar_after_x4", rf_if.rs1_data_o, 32'h0);
    check("ar_after_x3", rf_if.rs2_data_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
